// File: rtl/lam_unit.sv
// rtl/lam_unit.sv - load/store execution unit with single-outstanding req/ack memory port
// Stores read the source register via selM_in/outM; loads write back through selM_out/busM.
module lam_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_store,
  input  logic [1:0]  cmd_size,
  input  logic        cmd_unsigned,
  input  logic [31:0] cmd_addr,
  input  logic [4:0]  cmd_reg,
  output logic [4:0]  selM_in,
  input  logic [31:0] outM,
  output logic [4:0]  selM_out,
  output logic [31:0] busM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err_misaligned,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WB, ERR} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  l_lo;
  logic [1:0]  l_size;
  logic        l_uns;
  logic [4:0]  l_reg;

  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign cmd_ready = (state == IDLE) && reset;
  assign selM_in   = cmd_reg;
  assign busy      = (state != IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (cmd_size)
      2'b01:   misaligned = cmd_addr[0];
      2'b10:   misaligned = (cmd_addr[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Narrow stores replicate the datum across all lanes; byte enables pick the lane.
  always_comb begin
    st_wdata = outM;
    st_be    = 4'b1111;
    case (cmd_size)
      2'b00: begin
        st_wdata = {4{outM[7:0]}};
        st_be    = 4'b0001 << cmd_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{outM[15:0]}};
        st_be    = cmd_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{l_lo, 3'b000} +: 8];
    ld_half = l_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (l_size)
      2'b00:   ld_data = {{24{~l_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~l_uns & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      l_lo           <= '0;
      l_size         <= '0;
      l_uns          <= 1'b0;
      l_reg          <= '0;
      selM_out       <= '0;
      busM           <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            l_lo   <= cmd_addr[1:0];
            l_size <= cmd_size;
            l_uns  <= cmd_unsigned;
            l_reg  <= cmd_reg;
            cnt    <= '0;
            if (misaligned) begin
              state          <= ERR;
              err_misaligned <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= cmd_store;
              mem_addr  <= {cmd_addr[31:2], 2'b00};
              mem_wdata <= cmd_store ? st_wdata : 32'd0;
              mem_be    <= cmd_store ? st_be : 4'b1111;
            end
          end
        end
        REQ: begin
          // Ack is checked first so an ack on the last allowed cycle beats the timeout.
          if (mem_ack || cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            state     <= IDLE;
            if (!mem_ack) begin
              err_timeout <= 1'b1;
            end else if (!mem_we) begin
              state    <= WB;
              selM_out <= l_reg;
              busM     <= ld_data;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WB: begin
          selM_out <= '0;
          busM     <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lam_unit.sv
// tb/tb_lam_unit.sv - scoreboard bench for lam_unit
module tb_lam_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_store, cmd_unsigned;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, outM, busM, mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  cmd_reg, selM_in, selM_out;
  logic        mem_req, mem_we, mem_ack, busy, err_misaligned, err_timeout;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lam_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_store(cmd_store), .cmd_size(cmd_size), .cmd_unsigned(cmd_unsigned),
    .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .selM_in(selM_in), .outM(outM),
    .selM_out(selM_out), .busM(busM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} mreq_t;
  typedef struct packed {logic [4:0] sel; logic [31:0] data;} wb_t;

  mreq_t mq[$];
  wb_t   wq[$];
  int    tests = 0;
  int    fails = 0;

  function automatic mreq_t exp_mem(input logic store, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [31:0] data);
    mreq_t r;
    r.we    = store;
    r.addr  = addr & 32'hFFFF_FFFC;
    r.wdata = 32'd0;
    r.be    = 4'hF;
    if (store) begin
      if (size == 2'b00) begin
        r.wdata = data[7:0] * 32'h0101_0101;
        r.be    = 4'(1 << addr[1:0]);
      end else if (size == 2'b01) begin
        r.wdata = data[15:0] * 32'h0001_0001;
        r.be    = addr[1] ? 4'hC : 4'h3;
      end else begin
        r.wdata = data;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> (addr[1:0] * 8);
    if (size == 2'b00)
      return uns ? (sh & 32'hFF) : ((sh & 32'h80) != 0 ? (sh | 32'hFFFF_FF00) : (sh & 32'hFF));
    if (size == 2'b01)
      return uns ? (sh & 32'hFFFF) : ((sh & 32'h8000) != 0 ? (sh | 32'hFFFF_0000) : (sh & 32'hFFFF));
    return rdata;
  endfunction

  task automatic drive_cmd(input logic store, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [4:0] rg, input logic [31:0] data);
    cmd_valid = 1'b1; cmd_store = store; cmd_size = size; cmd_unsigned = uns;
    cmd_addr = addr; cmd_reg = rg; outM = data;
  endtask

  task automatic run_txn(input logic store, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [4:0] rg, input logic [31:0] data,
                         input logic [31:0] rdata, input int ack_delay);
    mreq_t e;
    wb_t   w;
    mq.push_back(exp_mem(store, size, addr, data));
    if (!store) begin
      w.sel  = rg;
      w.data = exp_load(size, uns, addr, rdata);
      wq.push_back(w);
    end
    drive_cmd(store, size, uns, addr, rg, data);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL accept_ready got %b exp 1", cmd_ready); end
    tests++; if (selM_in !== rg) begin fails++; $display("FAIL selM_in got %0d exp %0d", selM_in, rg); end
    @(negedge clk);
    cmd_valid = 1'b0; outM = $urandom;
    e = mq.pop_front();
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL req_start got %b exp 1", mem_req); end
    tests++;
    if ({mem_we, mem_addr, mem_wdata, mem_be} !== e) begin
      fails++; $display("FAIL mem_fields got we=%b a=%h d=%h be=%b exp we=%b a=%h d=%h be=%b",
                        mem_we, mem_addr, mem_wdata, mem_be, e.we, e.addr, e.wdata, e.be);
    end
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, e}) begin
        fails++; $display("FAIL mem_hold cycle %0d got req=%b a=%h d=%h be=%b exp req=1 a=%h d=%h be=%b",
                          i, mem_req, mem_addr, mem_wdata, mem_be, e.addr, e.wdata, e.be);
      end
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL req_drop got %b exp 0", mem_req); end
    if (!store) begin
      w = wq.pop_front();
      tests++;
      if ({selM_out, busM} !== w) begin
        fails++; $display("FAIL writeback got sel=%0d bus=%h exp sel=%0d bus=%h", selM_out, busM, w.sel, w.data);
      end
      @(negedge clk);
    end
    tests++;
    if ({cmd_ready, selM_out, busM} !== {1'b1, 5'd0, 32'd0}) begin
      fails++; $display("FAIL idle_after got ready=%b sel=%0d bus=%h exp ready=1 sel=0 bus=0", cmd_ready, selM_out, busM);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_size = 2'b00; cmd_unsigned = 1'b0;
    cmd_addr = '0; cmd_reg = '0; outM = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({cmd_ready, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_be, selM_out, busM, err_misaligned, err_timeout} !== '0) begin
      fails++; $display("FAIL reset_outputs got ready=%b busy=%b req=%b be=%b sel=%0d bus=%h", cmd_ready, busy, mem_req, mem_be, selM_out, busM);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_word_store;
    run_txn(1'b1, 2'b10, 1'b0, 32'h100, 5'd5, 32'hDEADBEEF, 32'h0, 3);
  endtask

  task automatic test_byte_load;
    run_txn(1'b0, 2'b00, 1'b0, 32'h203, 5'd7, 32'h0, 32'h80112233, 0);
    run_txn(1'b0, 2'b00, 1'b1, 32'h203, 5'd7, 32'h0, 32'h80112233, 1);
    run_txn(1'b0, 2'b01, 1'b0, 32'h206, 5'd9, 32'h0, 32'h9ABC1234, 0);
  endtask

  task automatic test_half_store;
    run_txn(1'b1, 2'b01, 1'b0, 32'h12, 5'd4, 32'h0000ABCD, 32'h0, 0);
    run_txn(1'b1, 2'b00, 1'b0, 32'h31, 5'd6, 32'h000000A5, 32'h0, 2);
  endtask

  task automatic test_misaligned;
    logic [31:0] addrs[3];
    logic [1:0]  sizes[3];
    addrs = '{32'h13, 32'h102, 32'h40};
    sizes = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b1, sizes[i], 1'b0, addrs[i], 5'd2, 32'h1234);
      @(negedge clk);
      cmd_valid = 1'b0;
      tests++;
      if ({err_misaligned, mem_req, busy} !== 3'b101) begin
        fails++; $display("FAIL misaligned_pulse case %0d got err=%b req=%b busy=%b exp 1 0 1", i, err_misaligned, mem_req, busy);
      end
      @(negedge clk);
      tests++;
      if ({err_misaligned, mem_req, cmd_ready} !== 3'b001) begin
        fails++; $display("FAIL misaligned_end case %0d got err=%b req=%b ready=%b exp 0 0 1", i, err_misaligned, mem_req, cmd_ready);
      end
    end
  endtask

  task automatic test_timeout;
    int reqs = 0, errs = 0, wbs = 0;
    drive_cmd(1'b0, 2'b10, 1'b0, 32'h44, 5'd3, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem_req === 1'b1) reqs++;
      if (err_timeout === 1'b1) errs++;
      if (selM_out !== 5'd0) wbs++;
      @(negedge clk);
    end
    tests++; if (reqs != 4) begin fails++; $display("FAIL timeout_req_cycles got %0d exp 4", reqs); end
    tests++; if (errs != 1) begin fails++; $display("FAIL timeout_pulses got %0d exp 1", errs); end
    tests++; if (wbs != 0) begin fails++; $display("FAIL timeout_writeback got %0d exp 0", wbs); end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({selM_out, busy, cmd_ready} !== {5'd0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL late_ack got sel=%0d busy=%b ready=%b exp 0 0 1", selM_out, busy, cmd_ready);
    end
    run_txn(1'b1, 2'b10, 1'b0, 32'h48, 5'd8, 32'h0BADF00D, 32'h0, 0);
  endtask

  task automatic test_ack_final;
    run_txn(1'b0, 2'b10, 1'b0, 32'h80, 5'd11, 32'h0, 32'h13579BDF, 3);
  endtask

  task automatic test_load_x0;
    run_txn(1'b0, 2'b10, 1'b0, 32'h90, 5'd0, 32'h0, 32'hCAFEF00D, 1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 2));
      a  = $urandom & ~((32'd1 << sz) - 32'd1);
      run_txn(1'($urandom), sz, 1'($urandom), a, 5'($urandom_range(1, 31)), $urandom, $urandom,
              $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_midop;
    drive_cmd(1'b0, 2'b10, 1'b0, 32'hA0, 5'd12, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_req, busy, cmd_ready} !== 3'b000) begin
      fails++; $display("FAIL reset_midop got req=%b busy=%b ready=%b exp 0 0 0", mem_req, busy, cmd_ready);
    end
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({selM_out, busy, cmd_ready} !== {5'd0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL reset_late_ack got sel=%0d busy=%b ready=%b exp 0 0 1", selM_out, busy, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_ack_final();
    test_load_x0();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lam_unit.md
Name: lam_unit

Overview:
- Load/store ("LAM") execution unit on the memory-side port pair of the register bank.
- Accepts one load/store command at a time. For stores, reads the source register through selM_in/outM; for loads, writes the result back through selM_out/busM.
- Drives a single-outstanding req/ack data-memory interface with byte enables, alignment checking and an ack timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ without mem_ack before abort (1..65535).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit can accept a command.
- cmd_store  in  1  1=store, 0=load.
- cmd_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- cmd_unsigned  in  1  load zero-extend (1) / sign-extend (0); ignored for stores.
- cmd_addr  in  32  effective byte address.
- cmd_reg  in  5  store source register or load destination register.
- selM_in  out  5  register bank read select.
- outM  in  32  register bank read data (combinational from selM_in).
- selM_out  out  5  register bank write select; 0 = no write.
- busM  out  32  register bank write data.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  request completed.
- mem_rdata  in  32  read data, valid with mem_ack.
- busy  out  1  state != IDLE.
- err_misaligned  out  1  one-cycle error pulse.
- err_timeout  out  1  one-cycle error pulse.

Behaviour:
- Clock and reset: clk is the single clock. reset is synchronous and active-low: sampled low on a posedge, it returns the unit to IDLE.
- Reset values, and outputs while reset is low: every registered output is 0, including selM_out, busM, mem_* and err_*. cmd_ready=0 while reset is low.
- Reset mid-operation: an in-flight request is dropped. mem_req is 0 after that edge. No writeback occurs, and a late mem_ack is ignored.
- FSM states: IDLE, REQ, WB, ERR.
- cmd_ready = (state==IDLE) and reset high.
- selM_in = cmd_reg, combinationally, in every state.
- Accept: cmd_valid&cmd_ready at edge T. At that edge, capture addr, size, unsigned, reg, store, and outM (store data).
  - Misaligned or illegal command goes to ERR. Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Otherwise go to REQ.
- ERR: lasts one cycle, with err_misaligned=1. No memory access and no writeback. Then IDLE.
- REQ:
  - mem_req=1. mem_we=store. mem_addr={addr[31:2],2'b00}.
  - All mem_* outputs are held stable until ack.
  - First REQ cycle is T+1.
- Store data and enables:
  - byte: wdata = byte replicated ×4; be = 0001<<addr[1:0].
  - half: wdata = half replicated ×2; be = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - word: wdata = data; be = 1111.
- Load: mem_we=0, mem_be=1111, mem_wdata=0.
- mem_ack high at an edge in REQ:
  - mem_req drops next cycle.
  - store → IDLE.
  - load → WB.
- mem_ack outside REQ is ignored.
- Load extraction: byte lane addr[1:0], or half lane addr[1]. Sign- or zero-extend to 32 bits per cmd_unsigned. Word loads pass through.
- WB:
  - Lasts exactly one cycle, with selM_out=reg and busM=extended data.
  - Load to x0 performs the memory access but drives selM_out=0, so no write.
  - The register bank commits on the following negedge. Then IDLE.
- Store latency: accept T → mem_req at T+1 → IDLE the cycle after ack.
- Load latency: minimum T → WB at T+2 (ack in first REQ cycle). Next command accepted at T+3.
- Timeout:
  - A cycle counter resets on entering REQ and increments each REQ cycle without ack.
  - When TIMEOUT_CYCLES REQ cycles have elapsed without ack: drop mem_req, pulse err_timeout for one cycle, go to IDLE, no writeback.
  - Ack on the final allowed cycle wins over timeout.
- selM_out and busM are 0 outside WB.
- err_* are 0 except for their single pulse cycle.

Test Plan:
- Word store: outM=0xDEADBEEF, addr=0x100, size=10, reg=5 → mem_req at T+1, mem_we=1, mem_addr=0x100, be=1111, wdata=0xDEADBEEF; ack after 3 cycles → back to IDLE, selM_out stays 0.
- Signed byte load: addr=0x203, size=00, unsigned=0, reg=7, mem_rdata=0x80112233 → mem_addr=0x200; one WB cycle with selM_out=7, busM=0xFFFFFF80. Same with unsigned=1 → busM=0x00000080.
- Half store: addr=0x12, outM=0x0000ABCD → be=1100, wdata=0xABCDABCD. Misaligned half at addr 0x13 → err_misaligned pulses at T+1, mem_req never asserts.
- Timeout: TIMEOUT_CYCLES=4, load with mem_ack held 0 → mem_req high for exactly 4 cycles, err_timeout pulses once, no WB. A later ack is ignored and the next command is accepted.
- Load to x0: reg=0, ack → memory access occurs, selM_out remains 0 throughout.
- Reset during REQ: reset=0 for one edge → mem_req=0, busy=0, cmd_ready=0 while low. A later ack produces no WB. After release, cmd_ready=1.
